ibpl_out_seq: RTL and testbench

- Output-enable sequencer and drive controller for the 6-channel interbackplane output cardlet.
- Takes the per-channel output-enable requests from cardlet configuration and turns channels on one at a time. Each turn-on is followed by a settle gap, which limits simultaneous switching on the backplane drivers.
- Disables apply immediately.
- Gates the output data, drives direction and LED status, and flags input/output enable conflicts.

---
 rtl/ibpl_out_seq.sv | 130 +++++++++++++
 tb/tb_ibpl_out_seq.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibpl_out_seq.sv
// ibpl_out_seq: output-enable sequencer and drive controller for the 6-channel interbackplane output cardlet.
// Defining IBPL_OUT_ACT_STRETCH_EN stretches the activity LEDs by STRETCH_CYC cycles.
module ibpl_out_seq #(
   parameter int unsigned SETTLE_CYC  = 16,
   parameter int unsigned STRETCH_CYC = 1000
) (
   input  logic       clk,
   input  logic       nReset,
   input  logic [5:0] en_req,
   input  logic [5:0] in_en,
   input  logic [5:0] out_data_in,
   output logic [5:0] diob_out,
   output logic [5:0] diob_dir,
   output logic [5:0] out_en_eff,
   output logic [7:0] diob_led1,
   output logic [7:0] diob_led2,
   output logic       busy,
   output logic       plugin_error
);
   localparam int unsigned N_CH  = 6;
   localparam int unsigned CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

   typedef enum logic {IDLE, SETTLE} state_t;

   state_t           state;
   logic [2:0]       rr_ptr;
   logic [CNT_W-1:0] cnt;
   logic [N_CH-1:0]  pending;
   logic [N_CH-1:0]  rot;
   logic [N_CH-1:0]  grant_oh;
   logic [N_CH-1:0]  activity;
   logic [2:0]       off;
   logic [2:0]       grant_idx;
   logic [2:0]       next_ptr;
   logic [3:0]       sum;
   logic             grant_vld;
   logic             ready;

   // Round-robin pick: rotate pending so bit 0 is rr_ptr, take the lowest set bit, rotate back.
   always_comb begin
      pending = en_req & ~out_en_eff;
      unique case (rr_ptr)
         3'd1:    rot = {pending[0],   pending[5:1]};
         3'd2:    rot = {pending[1:0], pending[5:2]};
         3'd3:    rot = {pending[2:0], pending[5:3]};
         3'd4:    rot = {pending[3:0], pending[5:4]};
         3'd5:    rot = {pending[4:0], pending[5]};
         default: rot = pending;
      endcase
      off = 3'd0;
      for (int k = N_CH - 1; k >= 0; k--) begin
         if (rot[k]) off = 3'(k);
      end
      sum       = {1'b0, rr_ptr} + {1'b0, off};
      grant_idx = (sum >= 4'd6) ? 3'(sum - 4'd6) : sum[2:0];
      next_ptr  = (grant_idx == 3'd5) ? 3'd0 : grant_idx + 3'd1;
      grant_oh  = 6'b000001 << grant_idx;
      grant_vld = |pending;
   end

   // Channels are only granted once the pads have been switched to output mode.
   assign ready = &diob_dir;

   always_ff @(posedge clk) begin
      if (!nReset) begin
         state        <= IDLE;
         rr_ptr       <= 3'd0;
         cnt          <= '0;
         out_en_eff   <= '0;
         diob_out     <= '0;
         diob_dir     <= '0;
         diob_led1    <= '0;
         diob_led2    <= '0;
         busy         <= 1'b0;
         plugin_error <= 1'b0;
      end else begin
         diob_dir     <= 6'h3F;
         diob_out     <= out_data_in & out_en_eff;
         plugin_error <= |(in_en & ~out_en_eff);
         diob_led1    <= {2'b00, out_en_eff};
         diob_led2    <= {2'b00, activity};
         out_en_eff   <= out_en_eff & en_req;
         unique case (state)
            IDLE: begin
               if (grant_vld && ready) begin
                  out_en_eff <= (out_en_eff & en_req) | grant_oh;
                  rr_ptr     <= next_ptr;
                  cnt        <= CNT_W'(SETTLE_CYC - 1);
                  busy       <= 1'b1;
                  state      <= SETTLE;
               end
            end
            SETTLE: begin
               if (cnt == '0) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef IBPL_OUT_ACT_STRETCH_EN
   localparam int unsigned ACT_W = $clog2(STRETCH_CYC + 1);

   logic [ACT_W-1:0] act_cnt [N_CH];

   // Per-channel hold counter: reload while driving high, bleed down otherwise.
   always_ff @(posedge clk) begin
      for (int i = 0; i < N_CH; i++) begin
         if (!nReset)              act_cnt[i] <= '0;
         else if (diob_out[i])     act_cnt[i] <= ACT_W'(STRETCH_CYC);
         else if (act_cnt[i] != '0) act_cnt[i] <= act_cnt[i] - ACT_W'(1);
      end
   end

   always_comb begin
      activity = '0;
      for (int i = 0; i < N_CH; i++) begin
         activity[i] = diob_out[i] | (act_cnt[i] != '0);
      end
   end
`else
   assign activity = diob_out;
`endif

endmodule

// File: tb/tb_ibpl_out_seq.sv
// Self-checking bench for ibpl_out_seq: directed scenarios plus random traffic against a timestamp-based model.
module tb_ibpl_out_seq;
   localparam int unsigned SETTLE  = 16;
   localparam int unsigned STRETCH = 10;

   logic       clk = 1'b0;
   logic       nReset = 1'b0;
   logic [5:0] en_req = '0;
   logic [5:0] in_en = '0;
   logic [5:0] out_data_in = '0;
   logic [5:0] diob_out, diob_dir, out_en_eff;
   logic [7:0] diob_led1, diob_led2;
   logic       busy, plugin_error;

   int n_pass = 0;
   int n_total = 0;

   ibpl_out_seq #(.SETTLE_CYC(SETTLE), .STRETCH_CYC(STRETCH)) dut (
      .clk(clk), .nReset(nReset), .en_req(en_req), .in_en(in_en), .out_data_in(out_data_in),
      .diob_out(diob_out), .diob_dir(diob_dir), .out_en_eff(out_en_eff), .diob_led1(diob_led1),
      .diob_led2(diob_led2), .busy(busy), .plugin_error(plugin_error)
   );

   always #5 clk = ~clk;

   // Reference model: grants are spaced by timestamps, LED stretch by time since last high output.
   logic [5:0] m_out = '0, m_dir = '0, m_en = '0;
   logic [7:0] m_led1 = '0, m_led2 = '0;
   logic       m_busy = 1'b0, m_err = 1'b0;
   logic [5:0] m_act, m_pend, m_nen;
   int         cyc = 0, ptr = 0, last_grant = -100000, idx;
   int         last_hi [6];
   bit         found;

   always @(posedge clk) begin
      cyc++;
      if (!nReset) begin
         m_out = '0; m_dir = '0; m_en = '0; m_led1 = '0; m_led2 = '0; m_busy = 1'b0; m_err = 1'b0;
         ptr = 0; last_grant = -100000;
         for (int i = 0; i < 6; i++) last_hi[i] = -100000;
      end else begin
         for (int i = 0; i < 6; i++) begin
            if (m_out[i]) last_hi[i] = cyc - 1;
`ifdef IBPL_OUT_ACT_STRETCH_EN
            m_act[i] = ((cyc - 1 - last_hi[i]) <= int'(STRETCH));
`else
            m_act[i] = m_out[i];
`endif
         end
         m_led2 = {2'b00, m_act};
         m_led1 = {2'b00, m_en};
         m_err  = |(in_en & ~m_en);
         m_out  = out_data_in & m_en;
         m_nen  = m_en & en_req;
         m_pend = en_req & ~m_en;
         if (m_dir == 6'h3F && cyc > last_grant + int'(SETTLE) && m_pend != 6'h00) begin
            found = 1'b0;
            for (int k = 0; k < 6; k++) begin
               idx = (ptr + k) % 6;
               if (!found && m_pend[idx]) begin
                  found = 1'b1;
                  m_nen[idx] = 1'b1;
                  ptr = (idx + 1) % 6;
                  last_grant = cyc;
               end
            end
         end
         m_en   = m_nen;
         m_busy = (cyc < last_grant + int'(SETTLE));
         m_dir  = 6'h3F;
      end
   end

   task automatic do_reset(input logic [5:0] req);
      @(negedge clk);
      nReset = 1'b0; en_req = req; in_en = '0; out_data_in = '0;
      repeat (5) @(negedge clk);
      nReset = 1'b1;
   endtask

   task automatic test_reset();
      nReset = 1'b0; en_req = 6'h3F; in_en = '0; out_data_in = '0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_total++;
         if ({diob_out, diob_dir, out_en_eff, diob_led1, diob_led2, busy, plugin_error} !== 36'd0)
            $display("FAIL reset_hold got=%h exp=0", {diob_out, diob_dir, out_en_eff, diob_led1, diob_led2, busy, plugin_error});
         else n_pass++;
      end
      nReset = 1'b1;
      @(negedge clk);
      n_total++;
      if ({diob_dir, out_en_eff, busy} !== {6'h3F, 6'h00, 1'b0})
         $display("FAIL reset_dir got dir=%h en=%h busy=%b exp dir=3f en=00 busy=0", diob_dir, out_en_eff, busy);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if ({out_en_eff, busy} !== {6'h01, 1'b1})
         $display("FAIL reset_first_grant got en=%h busy=%b exp en=01 busy=1", out_en_eff, busy);
      else n_pass++;
   endtask

   task automatic test_stagger();
      int         t_step[$];
      logic [5:0] v_step[$];
      logic [5:0] prev = '0;
      logic [5:0] expv;
      int         low_cnt = 0;
      do_reset(6'h3F);
      for (int c = 0; c < 110; c++) begin
         @(negedge clk);
         n_total++;
         if ({diob_out, diob_dir, out_en_eff, diob_led1, diob_led2, busy, plugin_error} !== {m_out, m_dir, m_en, m_led1, m_led2, m_busy, m_err})
            $display("FAIL stagger_model c=%0d got=%h exp=%h", c, {diob_out, diob_dir, out_en_eff, diob_led1, diob_led2, busy, plugin_error}, {m_out, m_dir, m_en, m_led1, m_led2, m_busy, m_err});
         else n_pass++;
         if (out_en_eff !== prev) begin t_step.push_back(c); v_step.push_back(out_en_eff); end
         if (v_step.size() > 0 && v_step.size() < 6 && !busy) low_cnt++;
         prev = out_en_eff;
      end
      n_total++;
      if (v_step.size() != 6) $display("FAIL stagger_steps got=%0d exp=6", v_step.size());
      else n_pass++;
      for (int k = 0; k < v_step.size() && k < 6; k++) begin
         expv = 6'((1 << (k + 1)) - 1);
         n_total++;
         if (v_step[k] !== expv) $display("FAIL stagger_value k=%0d got=%h exp=%h", k, v_step[k], expv);
         else n_pass++;
         if (k > 0) begin
            n_total++;
            if (t_step[k] - t_step[k-1] != 17) $display("FAIL stagger_gap k=%0d got=%0d exp=17", k, t_step[k] - t_step[k-1]);
            else n_pass++;
         end
      end
      n_total++;
      if (low_cnt != 5) $display("FAIL stagger_busy_low got=%0d exp=5", low_cnt);
      else n_pass++;
   endtask

   task automatic test_round_robin();
      int         order[$];
      int         t_rise[$];
      logic [5:0] prev = '0, rose;
      do_reset(6'h00);
      for (int c = 0; c < 45; c++) begin
         @(negedge clk);
         n_total++;
         if ({diob_out, diob_dir, out_en_eff, diob_led1, diob_led2, busy, plugin_error} !== {m_out, m_dir, m_en, m_led1, m_led2, m_busy, m_err})
            $display("FAIL rr_model c=%0d got=%h exp=%h", c, {diob_out, diob_dir, out_en_eff, diob_led1, diob_led2, busy, plugin_error}, {m_out, m_dir, m_en, m_led1, m_led2, m_busy, m_err});
         else n_pass++;
         rose = out_en_eff & ~prev;
         for (int i = 0; i < 6; i++) if (rose[i]) begin order.push_back(i); t_rise.push_back(c); end
         if (c == 0) en_req = 6'h04;
         if (rose[2]) en_req = 6'h15;
         prev = out_en_eff;
      end
      n_total++;
      if (order.size() != 3) $display("FAIL rr_count got=%0d exp=3", order.size());
      else n_pass++;
      if (order.size() == 3) begin
         n_total++;
         if ({order[0], order[1], order[2]} !== {32'd2, 32'd4, 32'd0})
            $display("FAIL rr_order got=%0d,%0d,%0d exp=2,4,0", order[0], order[1], order[2]);
         else n_pass++;
         n_total++;
         if (t_rise[2] - t_rise[1] != 17) $display("FAIL rr_gap got=%0d exp=17", t_rise[2] - t_rise[1]);
         else n_pass++;
      end
   endtask

   task automatic test_disable();
      int busy_cnt = 0;
      do_reset(6'h3F);
      out_data_in = 6'h3F;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         n_total++;
         if ({diob_out, diob_dir, out_en_eff, diob_led1, diob_led2, busy, plugin_error} !== {m_out, m_dir, m_en, m_led1, m_led2, m_busy, m_err})
            $display("FAIL disable_model c=%0d got=%h exp=%h", c, {diob_out, diob_dir, out_en_eff, diob_led1, diob_led2, busy, plugin_error}, {m_out, m_dir, m_en, m_led1, m_led2, m_busy, m_err});
         else n_pass++;
         if (busy === 1'b1) busy_cnt++;
         if (c == 5) begin
            n_total++;
            if ({out_en_eff, busy} !== {6'h00, 1'b1}) $display("FAIL disable_now got en=%h busy=%b exp en=00 busy=1", out_en_eff, busy);
            else n_pass++;
         end
         if (c == 6) begin
            n_total++;
            if (diob_out !== 6'h00) $display("FAIL disable_data got=%h exp=00", diob_out);
            else n_pass++;
         end
         if (c == 4) en_req = 6'h00;
      end
      n_total++;
      if (busy_cnt != 16) $display("FAIL disable_settle got=%0d exp=16", busy_cnt);
      else n_pass++;
   endtask

   task automatic test_gating_error();
      do_reset(6'h0F);
      for (int c = 0; c < 100 && out_en_eff !== 6'h0F; c++) begin
         @(negedge clk);
         n_total++;
         if ({diob_out, diob_dir, out_en_eff, diob_led1, diob_led2, busy, plugin_error} !== {m_out, m_dir, m_en, m_led1, m_led2, m_busy, m_err})
            $display("FAIL gate_model c=%0d got=%h exp=%h", c, {diob_out, diob_dir, out_en_eff, diob_led1, diob_led2, busy, plugin_error}, {m_out, m_dir, m_en, m_led1, m_led2, m_busy, m_err});
         else n_pass++;
      end
      n_total++;
      if (out_en_eff !== 6'h0F) $display("FAIL gate_reach got=%h exp=0f", out_en_eff);
      else n_pass++;
      out_data_in = 6'h2A; in_en = 6'h10;
      @(negedge clk);
      n_total++;
      if ({diob_out, plugin_error} !== {6'h0A, 1'b1}) $display("FAIL gate_data got out=%h err=%b exp out=0a err=1", diob_out, plugin_error);
      else n_pass++;
      en_req = 6'h1F;
      for (int c = 0; c < 40 && out_en_eff[4] !== 1'b1; c++) @(negedge clk);
      n_total++;
      if ({out_en_eff[4], plugin_error} !== 2'b11) $display("FAIL err_hold got en4=%b err=%b exp en4=1 err=1", out_en_eff[4], plugin_error);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if (plugin_error !== 1'b0) $display("FAIL err_clear got=%b exp=0", plugin_error);
      else n_pass++;
   endtask

   task automatic test_stretch();
      int hi_cnt = 0;
      int exp_cnt;
`ifdef IBPL_OUT_ACT_STRETCH_EN
      exp_cnt = int'(STRETCH) + 1;
`else
      exp_cnt = 1;
`endif
      do_reset(6'h01);
      repeat (3) @(negedge clk);
      out_data_in = 6'h01;
      @(negedge clk);
      out_data_in = 6'h00;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         n_total++;
         if ({diob_out, diob_dir, out_en_eff, diob_led1, diob_led2, busy, plugin_error} !== {m_out, m_dir, m_en, m_led1, m_led2, m_busy, m_err})
            $display("FAIL stretch_model c=%0d got=%h exp=%h", c, {diob_out, diob_dir, out_en_eff, diob_led1, diob_led2, busy, plugin_error}, {m_out, m_dir, m_en, m_led1, m_led2, m_busy, m_err});
         else n_pass++;
         if (diob_led2[0] === 1'b1) hi_cnt++;
      end
      n_total++;
      if (hi_cnt != exp_cnt) $display("FAIL stretch_len got=%0d exp=%0d", hi_cnt, exp_cnt);
      else n_pass++;
   endtask

   task automatic test_random();
      do_reset(6'h00);
      for (int c = 0; c < 1200; c++) begin
         @(negedge clk);
         n_total++;
         if ({diob_out, diob_dir, out_en_eff, diob_led1, diob_led2, busy, plugin_error} !== {m_out, m_dir, m_en, m_led1, m_led2, m_busy, m_err})
            $display("FAIL random_model c=%0d got=%h exp=%h", c, {diob_out, diob_dir, out_en_eff, diob_led1, diob_led2, busy, plugin_error}, {m_out, m_dir, m_en, m_led1, m_led2, m_busy, m_err});
         else n_pass++;
         if ($urandom_range(0, 9) == 0) en_req = 6'($urandom);
         if ($urandom_range(0, 19) == 0) in_en = 6'($urandom);
         out_data_in = 6'($urandom);
         if (!nReset) nReset = ($urandom_range(0, 2) != 0);
         else if ($urandom_range(0, 149) == 0) nReset = 1'b0;
      end
      nReset = 1'b1;
   endtask

   initial begin
      test_reset();
      test_stagger();
      test_round_robin();
      test_disable();
      test_gating_error();
      test_stretch();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
